pc_select_reg: RTL

PC_SELECT_REG -- requirements
Module: pc_select_reg

---
 rtl/pc_sel_pkg.sv | 14 +
 rtl/prio_enc.sv | 26 ++
 rtl/pc_select_reg.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pc_sel_pkg.sv
// Shared definitions for the PC select register.
//   state_t : sequencer states (BOOT, RUN, PEND)
//   PC_INC  : sequential fetch increment in bytes
package pc_sel_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int PC_INC = 4;

endpackage

// File: rtl/prio_enc.sv
// Priority encoder: the highest set bit of req wins.
// Ports:
//   req : request vector, N bits
//   idx : index of the highest set bit (0 when none)
//   any : at least one request bit is set
module prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  // Ascending scan: each later hit overrides, so the top index is kept.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx = ($clog2(N))'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_select_reg.sv
// PC select register: holds the fetch PC, advancing by PC_INC or loading
// the highest-priority redirect target. A redirect arriving during a stall
// is held in a one-entry pending buffer and applied when the stall drops,
// unless a strictly higher-priority live request arrives that cycle.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   stall     : hold the PC
//   req       : per-source redirect requests (NUM_SRC)
//   src_addr  : flat targets, source i at [i*WIDTH +: WIDTH]
//   pc_out    : registered PC
//   pc_valid  : pc_out usable (low in BOOT)
//   redirect  : one-cycle pulse when pc_out was loaded from a source
//   sel_idx   : source index of the last applied redirect
//   pend      : a redirect is buffered
//   misalign  : (PC_ALIGN_CHECK_EN only) pulses with redirect when the
//               target had bits[1:0]!=0; those bits are cleared in pc_out
module pc_select_reg
  import pc_sel_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               NUM_SRC  = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic [NUM_SRC-1:0]         req,
  input  logic [NUM_SRC*WIDTH-1:0]   src_addr,
  output logic [WIDTH-1:0]           pc_out,
  output logic                       pc_valid,
  output logic                       redirect,
  output logic [$clog2(NUM_SRC)-1:0] sel_idx,
  output logic                       pend
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                       misalign
`endif
);

  localparam int IW = $clog2(NUM_SRC);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             redir_q, redir_d;
  logic [IW-1:0]    sel_q, sel_d;
  logic [WIDTH-1:0] paddr_q, paddr_d;
  logic [IW-1:0]    pidx_q, pidx_d;

  logic [WIDTH-1:0] src [NUM_SRC];
  logic [IW-1:0]    live_idx;
  logic             live_any;
  logic [WIDTH-1:0] live_addr;

  logic             apply;
  logic [WIDTH-1:0] tgt;
  logic [IW-1:0]    tgt_idx;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src[i] = src_addr[i*WIDTH +: WIDTH];
  end

  prio_enc #(.N(NUM_SRC)) u_prio (
    .req (req),
    .idx (live_idx),
    .any (live_any)
  );

  assign live_addr = src[live_idx];

`ifdef PC_ALIGN_CHECK_EN
  logic mis_q, mis_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = 1'b0;
    sel_d   = sel_q;
    paddr_d = paddr_q;
    pidx_d  = pidx_q;
    apply   = 1'b0;
    tgt     = live_addr;
    tgt_idx = live_idx;
`ifdef PC_ALIGN_CHECK_EN
    mis_d   = 1'b0;
`endif
    case (state_q)
      // Requests are ignored while booting; PC stays at RESET_PC.
      BOOT: state_d = RUN;
      RUN: begin
        if (stall) begin
          if (live_any) begin
            paddr_d = live_addr;
            pidx_d  = live_idx;
            state_d = PEND;
          end
        end else if (live_any) begin
          apply = 1'b1;
        end else begin
          pc_d = pc_q + WIDTH'(PC_INC);
        end
      end
      PEND: begin
        if (stall) begin
          // Equal priority overwrites so the newest target of that source wins.
          if (live_any && (live_idx >= pidx_q)) begin
            paddr_d = live_addr;
            pidx_d  = live_idx;
          end
        end else begin
          apply   = 1'b1;
          state_d = RUN;
          if (!(live_any && (live_idx > pidx_q))) begin
            tgt     = paddr_q;
            tgt_idx = pidx_q;
          end
        end
      end
      default: state_d = BOOT;
    endcase

    if (apply) begin
      redir_d = 1'b1;
      sel_d   = tgt_idx;
`ifdef PC_ALIGN_CHECK_EN
      pc_d    = {tgt[WIDTH-1:2], 2'b00};
      mis_d   = |tgt[1:0];
`else
      pc_d    = tgt;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      redir_q <= 1'b0;
      sel_q   <= '0;
      paddr_q <= '0;
      pidx_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      sel_q   <= sel_d;
      paddr_q <= paddr_d;
      pidx_q  <= pidx_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_d;
  end
  assign misalign = mis_q;
`endif

  assign pc_out   = pc_q;
  assign pc_valid = (state_q != BOOT);
  assign redirect = redir_q;
  assign sel_idx  = sel_q;
  assign pend     = (state_q == PEND);

endmodule
